// File: rtl/stopwatch_core.sv
// stopwatch_core: centisecond timebase and MM:SS.CC BCD counter with run/pause, clear and lap freeze.
// The registered display mux feeds the 7-segment decoders; the live count keeps running while the display is frozen.
module stopwatch_core #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100,
  parameter int PW      = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  // per-digit terminal values, {m1,m0,s1,s0,c1,c0}
  localparam logic [23:0] LIM = 24'h595999;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [23:0] cnt_q, cnt_d, lat_q, lat_d, disp_q, disp_d, inc;
  logic lap_q, lap_d, ovf_q, ovf_d, tick, wrap;
  assign tick = (state_q == RUN) && (presc_q == LAST);
  always_comb begin
    logic c;
    c = tick;
    inc = cnt_q;
    for (int i = 0; i < 6; i++) begin
      inc[4*i +: 4] = c ? ((cnt_q[4*i +: 4] == LIM[4*i +: 4]) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1) : cnt_q[4*i +: 4];
      c = c && (cnt_q[4*i +: 4] == LIM[4*i +: 4]);
    end
    wrap = c;
  end
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      cnt_d   = inc;
      ovf_d   = ovf_q | wrap;
    end
    // only the highest-priority control pulse acts; clear in RUN still swallows the rest
    if (clear) begin
      if (state_q == PAUSE) begin
        state_d = IDLE;
        presc_d = '0;
        cnt_d   = '0;
        lat_d   = '0;
        lap_d   = 1'b0;
        ovf_d   = 1'b0;
      end else if (state_q == IDLE) begin
        lap_d = 1'b0;
        ovf_d = 1'b0;
      end
    end else if (start_stop) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end else if (lap) begin
      if (lap_q && state_q != IDLE) begin
        lap_d = 1'b0;
      end else if (!lap_q && state_q == RUN) begin
        lap_d = 1'b1;
        lat_d = cnt_d;
      end
    end
    disp_d = lap_d ? lat_d : cnt_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      disp_q  <= '0;
      lap_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      disp_q  <= disp_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end
  assign digits     = disp_q;
  assign running    = (state_q == RUN);
  assign lap_active = lap_q;
  assign overflow   = ovf_q;
endmodule
